// File: rtl/fetch_seq.sv
// Byte-serial instruction fetch sequencer: opcode, up to two operands, then a
// decoder-driven execute step counter with trap and halt handling.
module fetch_seq #(
  parameter int MAX_STEP = 7
) (
  input  logic       clk,
  input  logic       rst,
  output logic       mem_req,
  input  logic       mem_ack,
  input  logic [7:0] mem_data,
  output logic       pc_inc,
  output logic [7:0] insn,
  output logic [7:0] d1,
  output logic [7:0] d2,
  output logic [2:0] is,
  input  logic [1:0] len,
  input  logic       step_last,
  input  logic       trap,
  input  logic       stall,
  output logic       exec,
  output logic       halted
);

  typedef enum logic [2:0] {
    IDLE, F_OP, F_D1, F_D2, EXEC, HALT
  } state_t;

  localparam logic [2:0] MAX = 3'(MAX_STEP);

  state_t     state_q, state_d;
  logic       eval_q, eval_d;
  logic       pc_inc_q, pc_inc_d;
  logic [7:0] insn_q, insn_d;
  logic [7:0] d1_q, d1_d;
  logic [7:0] d2_q, d2_d;
  logic [2:0] is_q, is_d;
  logic       xfer;
  logic       take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      eval_q   <= 1'b0;
      pc_inc_q <= 1'b0;
      insn_q   <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      is_q     <= '0;
    end else begin
      state_q  <= state_d;
      eval_q   <= eval_d;
      pc_inc_q <= pc_inc_d;
      insn_q   <= insn_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      is_q     <= is_d;
    end
  end

  assign xfer = mem_req & mem_ack;
  assign take = xfer & ~trap;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = F_OP;
      F_OP: if (xfer) state_d = F_D1;
      F_D1: begin
        // eval cycle: len now reflects the freshly latched opcode
        if (eval_q) begin
          if (len == 2'd0)      state_d = EXEC;
          else if (len == 2'd3) state_d = HALT;
        end else if (xfer) begin
          state_d = (len == 2'd2) ? F_D2 : EXEC;
        end
      end
      F_D2: if (xfer) state_d = EXEC;
      EXEC: begin
        if (!stall) begin
          if (step_last)       state_d = F_OP;
          else if (is_q == MAX) state_d = HALT;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (trap && state_q != IDLE) state_d = HALT;
  end

  always_comb begin
    insn_d   = insn_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    pc_inc_d = take;
    eval_d   = (state_q == F_OP) && (state_d == F_D1);
    if (take) begin
      unique case (state_q)
        F_OP: begin
          insn_d = mem_data;
          d1_d   = '0;
          d2_d   = '0;
        end
        F_D1:    d1_d = mem_data;
        F_D2:    d2_d = mem_data;
        default: ;
      endcase
    end
    is_d = is_q;
    if (state_q == EXEC && state_d == EXEC && !stall)
      is_d = is_q + 3'd1;
    if (state_d != EXEC) is_d = '0;
  end

  always_comb begin
    mem_req = (state_q == F_OP) || (state_q == F_D2) ||
              ((state_q == F_D1) && !eval_q);
    exec    = (state_q == EXEC);
    halted  = (state_q == HALT);
    pc_inc  = pc_inc_q;
    insn    = insn_q;
    d1      = d1_q;
    d2      = d2_q;
    is      = is_q;
  end

endmodule
